// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt request controller. Synchronises external lines,
//               latches rising edges as pending, applies a mask, and drives a
//               single prioritised request through the irq/iack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int NSRC    = 8,
  parameter int CAUSE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC-1:0]    irq_src,
  input  logic               mask_wr,
  input  logic [NSRC-1:0]    mask_din,
  input  logic               clr_wr,
  input  logic [NSRC-1:0]    clr_din,
  input  logic               iack,
  output logic               irq,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic [NSRC-1:0]    mask_q,
  output logic [NSRC-1:0]    pend_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SERV = 2'd2;

  logic [1:0]         state;
  logic [NSRC-1:0]    sync1;
  logic [NSRC-1:0]    sync2;
  logic [NSRC-1:0]    sync3;
  logic               iack_d;
  logic [NSRC-1:0]    src_edge;
  logic [NSRC-1:0]    enabled;
  logic [NSRC-1:0]    pend_next;
  logic [CAUSE_W-1:0] sel_idx;
  logic               any_en;
  logic               ack_fire;

  // sync1/sync2 resolve metastability; sync3 is the one-cycle-old copy for edge detect
  assign src_edge = sync2 & ~sync3;
  assign enabled  = pend_q & mask_q;
  assign any_en   = |enabled;
  // only an iack rising edge while a request is outstanding counts as an acknowledge
  assign ack_fire = (state == REQ) & iack & ~iack_d;

  // Three-stage input synchroniser / edge history for every source
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Delayed iack for rising/falling detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) iack_d <= 1'b0;
    else     iack_d <= iack;
  end

  // Pending next-state: new edge beats W1C, which beats the acknowledge clear
  always_comb begin
    pend_next = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (src_edge[i])
        pend_next[i] = 1'b1;
      else if (clr_wr && clr_din[i])
        pend_next[i] = 1'b0;
      else if (ack_fire && (irq_cause == CAUSE_W'(i)))
        pend_next[i] = 1'b0;
    end
  end

  // Pending and mask registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_next;
      if (mask_wr) mask_q <= mask_din;
    end
  end

  // Lowest enabled index wins; scanning downward leaves the lowest one last
  always_comb begin
    sel_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (enabled[i]) sel_idx = CAUSE_W'(i);
    end
  end

  // Handshake FSM: irq is registered and only high while in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_en) begin
            state     <= REQ;
            irq       <= 1'b1;
            irq_cause <= sel_idx;
          end
        end
        REQ: begin
          // request is never withdrawn; only an acknowledge moves on
          if (ack_fire) begin
            state <= SERV;
            irq   <= 1'b0;
          end
        end
        SERV: begin
          // iack low covers both a normal return and an ack pulse too short to see fall
          if (!iack) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Scoreboard bench for irq_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int NSRC    = 8;
  localparam int CAUSE_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NSRC-1:0]    irq_src;
  logic               mask_wr;
  logic [NSRC-1:0]    mask_din;
  logic               clr_wr;
  logic [NSRC-1:0]    clr_din;
  logic               iack;
  logic               irq;
  logic [CAUSE_W-1:0] irq_cause;
  logic [NSRC-1:0]    mask_q;
  logic [NSRC-1:0]    pend_q;

  int total = 0;
  int bad   = 0;
  int n_req = 0;

  // expected cause of every request, in order of issue
  int exp_q[$];

  // behavioural model state
  logic [NSRC-1:0] m_pend, m_mask, m_last, m_r1, m_r2;
  logic            m_busy, m_served, m_iack_prev;
  int              m_cause;
  logic            auto_ack;
  int              ack_hold;

  irq_ctrl #(.NSRC(NSRC), .CAUSE_W(CAUSE_W)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_wr(mask_wr),
    .mask_din(mask_din), .clr_wr(clr_wr), .clr_din(clr_din), .iack(iack),
    .irq(irq), .irq_cause(irq_cause), .mask_q(mask_q), .pend_q(pend_q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_last = '0; m_r1 = '0; m_r2 = '0;
    m_busy = 1'b0; m_served = 1'b0; m_iack_prev = 1'b0; m_cause = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference: a line first sampled high at edge k
  // becomes pending at edge k+2; a new request is announced via exp_q.
  task automatic model_edge();
    logic [NSRC-1:0] en, np;
    logic ackrise;
    en      = m_pend & m_mask;
    ackrise = iack && !m_iack_prev;
    np      = m_pend;
    for (int i = 0; i < NSRC; i++) begin
      if (m_r2[i])                             np[i] = 1'b1;
      else if (clr_wr && clr_din[i])           np[i] = 1'b0;
      else if (m_busy && ackrise && i == m_cause) np[i] = 1'b0;
    end
    if (!m_busy && !m_served) begin
      if (en != '0) begin
        m_cause = lowest(en);
        m_busy  = 1'b1;
        exp_q.push_back(m_cause);
      end
    end else if (m_busy) begin
      if (ackrise) begin
        m_busy   = 1'b0;
        m_served = 1'b1;
      end
    end else if (!iack) begin
      m_served = 1'b0;
    end
    m_pend = np;
    if (mask_wr) m_mask = mask_din;
    m_iack_prev = iack;
    m_r2   = m_r1;
    m_r1   = irq_src & ~m_last;
    m_last = irq_src;
  endtask

  task automatic check_outputs();
    chk("irq", {31'd0, irq}, {31'd0, m_busy});
    chk("pend_q", {24'd0, pend_q}, {24'd0, m_pend});
    chk("mask_q", {24'd0, mask_q}, {24'd0, m_mask});
    chk("irq_cause", {29'd0, irq_cause}, m_cause);
  endtask

  // Inputs are set before calling; one-shot writes are dropped afterwards.
  task automatic step();
    if (auto_ack) begin
      if (iack) begin
        if (ack_hold > 0) ack_hold--;
        else iack = 1'b0;
      end else if (irq && $urandom_range(0, 2) == 0) begin
        iack = 1'b1;
        ack_hold = $urandom_range(0, 3);
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    mask_wr = 1'b0;
    clr_wr  = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    for (int k = 0; k < 40 && !irq; k++) step();
    chk(name, {31'd0, irq}, 32'd1);
  endtask

  task automatic do_ack();
    iack = 1'b1; step(); step();
    iack = 1'b0; step(); step();
  endtask

  task automatic write_mask(input logic [NSRC-1:0] m);
    mask_wr = 1'b1; mask_din = m; step();
  endtask

  task automatic settle();
    irq_src = '0; iack = 1'b0;
    clr_wr = 1'b1; clr_din = '1; step();
    for (int k = 0; k < 4; k++) step();
    clr_wr = 1'b1; clr_din = '1; step();
    step();
  endtask

  // Monitor: every rising irq must match the next expected cause
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      irq_prev = 1'b0;
    end else begin
      if (irq && !irq_prev) begin
        n_req++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_request actual_cause=%0d required=none at %0t", irq_cause, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (irq_cause !== CAUSE_W'(e)) begin
            bad++;
            $display("FAIL request_cause actual=%0d required=%0d at %0t", irq_cause, e, $time);
          end
        end
      end
      irq_prev = irq;
    end
  end

  initial begin
    int n0;
    rst = 1'b1; irq_src = '0; mask_wr = 1'b0; mask_din = '0;
    clr_wr = 1'b0; clr_din = '0; iack = 1'b0; auto_ack = 1'b0; ack_hold = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_cause", {29'd0, irq_cause}, 32'd0);
    chk("reset_pend", {24'd0, pend_q}, 32'd0);
    chk("reset_mask", {24'd0, mask_q}, 32'd0);
    rst = 1'b0;
    step(); step();

    // single source
    write_mask(8'h04);
    irq_src = 8'h04; step(); irq_src = '0;
    wait_irq("single_irq");
    chk("single_cause", {29'd0, irq_cause}, 32'd2);
    iack = 1'b1; step();
    chk("single_ackclr", {31'd0, pend_q[2]}, 32'd0);
    step(); iack = 1'b0; step(); step();
    chk("single_idle", {31'd0, irq}, 32'd0);
    settle();

    // priority
    write_mask(8'hFF);
    irq_src = 8'h22; step(); irq_src = '0;
    wait_irq("prio_first");
    chk("prio_first_cause", {29'd0, irq_cause}, 32'd1);
    do_ack();
    wait_irq("prio_second");
    chk("prio_second_cause", {29'd0, irq_cause}, 32'd5);
    do_ack();
    settle();

    // masked pending
    write_mask(8'h00);
    irq_src = 8'h08; step(); irq_src = '0;
    for (int k = 0; k < 4; k++) step();
    chk("masked_pend", {24'd0, pend_q}, 32'h08);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    write_mask(8'h08);
    step();
    chk("unmask_irq", {31'd0, irq}, 32'd1);
    chk("unmask_cause", {29'd0, irq_cause}, 32'd3);
    do_ack();
    settle();

    // edge vs W1C
    write_mask(8'h00);
    irq_src = 8'h10; step(); step();
    clr_wr = 1'b1; clr_din = 8'h10; step();
    irq_src = '0;
    chk("edge_beats_w1c", {31'd0, pend_q[4]}, 32'd1);
    settle();

    // edge vs ack-clear
    write_mask(8'h04);
    irq_src = 8'h04; step(); irq_src = '0;
    wait_irq("coll_irq");
    irq_src = 8'h04; step(); irq_src = '0; step();
    iack = 1'b1; step();
    chk("edge_beats_ack", {31'd0, pend_q[2]}, 32'd1);
    step(); iack = 1'b0; step();
    wait_irq("coll_rereq");
    chk("coll_rereq_cause", {29'd0, irq_cause}, 32'd2);
    do_ack();
    settle();

    // level held high -> one request
    write_mask(8'h01);
    irq_src = 8'h01;
    n0 = n_req;
    for (int k = 0; k < 20; k++) begin
      if (irq && !iack) iack = 1'b1;
      else iack = 1'b0;
      step();
    end
    iack = 1'b0; irq_src = '0; step(); step(); step();
    chk("level_one_request", n_req - n0, 32'd1);

    // stale ack while idle
    irq_src = 8'h08; step(); irq_src = '0;
    for (int k = 0; k < 4; k++) step();
    iack = 1'b1; step(); iack = 1'b0; step(); step();
    chk("stale_pend", {24'd0, pend_q}, 32'h08);
    chk("stale_irq", {31'd0, irq}, 32'd0);
    settle();

    // reset mid-request
    write_mask(8'h04);
    irq_src = 8'h04; step(); irq_src = '0;
    wait_irq("rst_setup_irq");
    #2 rst = 1'b1;
    #1;
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_pend", {24'd0, pend_q}, 32'd0);
    chk("midrst_mask", {24'd0, mask_q}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();

    // randomized traffic
    auto_ack = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ NSRC'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        mask_wr = 1'b1; mask_din = NSRC'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 14) == 0) begin
        clr_wr = 1'b1; clr_din = NSRC'($urandom_range(0, 255));
      end
      step();
    end
    auto_ack = 1'b0;
    iack = 1'b0; irq_src = '0;
    step(); step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
